// File: rtl/sb_tx_msg_arbiter_pkg.sv
// Shared types and field widths for the sideband TX message arbiter.
package sb_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4,
        ERR       = 3'd5
    } arb_state_e;

    localparam int ST_W       = 4;
    localparam int SUB_W      = 4;
    localparam int MSGNO_W    = 4;
    localparam int INFO_W     = 3;
    localparam int DATA_W     = 16;
    localparam int BUSY_CNT_W = 4;
    localparam int DONE_CNT_W = 8;

    // Message fields captured from the granted requester.
    typedef struct packed {
        logic [ST_W-1:0]    state;
        logic [SUB_W-1:0]   sub_state;
        logic [MSGNO_W-1:0] msg_no;
        logic [INFO_W-1:0]  msg_info;
        logic [DATA_W-1:0]  data;
    } msg_fields_t;

    // Header-only messages carry an all-zero data bus.
    function automatic logic [DATA_W-1:0] payload(input logic has_data, input logic [DATA_W-1:0] d);
        return has_data ? d : '0;
    endfunction

endpackage

// File: rtl/sb_tx_msg_arbiter_if.sv
// Requester and SB TX wrapper signals of the message arbiter.
// master: arbiter view; slave: requesters + wrapper view.
interface sb_tx_msg_arbiter_if #(parameter int NUM_REQ = 3);
    import sb_tx_arb_pkg::*;

    logic [NUM_REQ-1:0]         i_req;
    logic [NUM_REQ-1:0]         i_req_has_data;
    logic [ST_W*NUM_REQ-1:0]    i_req_state;
    logic [SUB_W*NUM_REQ-1:0]   i_req_sub_state;
    logic [MSGNO_W*NUM_REQ-1:0] i_req_msg_no;
    logic [INFO_W*NUM_REQ-1:0]  i_req_msg_info;
    logic [DATA_W*NUM_REQ-1:0]  i_req_data;
    logic                       i_tx_busy;
    logic                       i_fifo_full;

    logic                       o_msg_valid;
    logic                       o_data_valid;
    logic [ST_W-1:0]            o_state;
    logic [SUB_W-1:0]           o_sub_state;
    logic [MSGNO_W-1:0]         o_msg_no;
    logic [INFO_W-1:0]          o_msg_info;
    logic [DATA_W-1:0]          o_data_bus;
    logic [NUM_REQ-1:0]         o_ack;
    logic [NUM_REQ-1:0]         o_err;
    logic [NUM_REQ-1:0]         o_grant;

    modport master (
        input  i_req, i_req_has_data, i_req_state, i_req_sub_state, i_req_msg_no,
               i_req_msg_info, i_req_data, i_tx_busy, i_fifo_full,
        output o_msg_valid, o_data_valid, o_state, o_sub_state, o_msg_no, o_msg_info,
               o_data_bus, o_ack, o_err, o_grant
    );

    modport slave (
        output i_req, i_req_has_data, i_req_state, i_req_sub_state, i_req_msg_no,
               i_req_msg_info, i_req_data, i_tx_busy, i_fifo_full,
        input  o_msg_valid, o_data_valid, o_state, o_sub_state, o_msg_no, o_msg_info,
               o_data_bus, o_ack, o_err, o_grant
    );

endinterface

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module sb_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] masked;
    logic [N-1:0] sel;
    logic         found;

    // Prefer requests at/above the pointer; fall back to the lowest request overall.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) masked[i] = req[i] && (IW'(i) >= ptr);
        sel   = (|masked) ? masked : req;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel[i] && !found) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sb_tx_msg_arbiter.sv
// Shares the sideband TX message path between NUM_REQ sources: round-robin grant,
// one-cycle issue pulse, tracks wrapper busy to completion, then acks (or errs on timeout).
module sb_tx_msg_arbiter
    import sb_tx_arb_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int BUSY_WAIT_MAX = 15,
    parameter int DONE_WAIT_MAX = 255
) (
    input  logic                i_divided_clk,
    input  logic                i_rst,
    sb_tx_msg_arbiter_if.master bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Per-requester views of the flat field buses.
    logic [NUM_REQ-1:0][ST_W-1:0]    req_state;
    logic [NUM_REQ-1:0][SUB_W-1:0]   req_sub_state;
    logic [NUM_REQ-1:0][MSGNO_W-1:0] req_msg_no;
    logic [NUM_REQ-1:0][INFO_W-1:0]  req_msg_info;
    logic [NUM_REQ-1:0][DATA_W-1:0]  req_data;

    assign req_state     = bus.i_req_state;
    assign req_sub_state = bus.i_req_sub_state;
    assign req_msg_no    = bus.i_req_msg_no;
    assign req_msg_info  = bus.i_req_msg_info;
    assign req_data      = bus.i_req_data;

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [NUM_REQ-1:0]      err_q, err_d;
    logic                    msg_valid_q, msg_valid_d;
    logic                    data_valid_q, data_valid_d;
    msg_fields_t             fields_q, fields_d;
    logic [BUSY_CNT_W-1:0]   busy_cnt_q, busy_cnt_d, busy_inc;
    logic [DONE_CNT_W-1:0]   done_cnt_q, done_cnt_d, done_inc;

    logic [NUM_REQ-1:0]      rr_gnt;
    logic [IW-1:0]           rr_idx;
    logic                    rr_any;

    sb_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (bus.i_req),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // Next-state, output and counter logic; counters stay 0 unless the state is held.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        grant_d      = grant_q;
        fields_d     = fields_q;
        ack_d        = '0;
        err_d        = '0;
        msg_valid_d  = 1'b0;
        data_valid_d = 1'b0;
        busy_cnt_d   = '0;
        done_cnt_d   = '0;
        busy_inc     = (busy_cnt_q == '1) ? busy_cnt_q : busy_cnt_q + 1'b1;
        done_inc     = (done_cnt_q == '1) ? done_cnt_q : done_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (rr_any && !bus.i_fifo_full && !bus.i_tx_busy) begin
                    state_d            = ISSUE;
                    grant_d            = rr_gnt;
                    idx_d              = rr_idx;
                    msg_valid_d        = 1'b1;
                    data_valid_d       = bus.i_req_has_data[rr_idx];
                    fields_d.state     = req_state[rr_idx];
                    fields_d.sub_state = req_sub_state[rr_idx];
                    fields_d.msg_no    = req_msg_no[rr_idx];
                    fields_d.msg_info  = req_msg_info[rr_idx];
                    fields_d.data      = payload(bus.i_req_has_data[rr_idx], req_data[rr_idx]);
                end
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (busy_inc == BUSY_CNT_W'(BUSY_WAIT_MAX)) begin
                    state_d = ERR;
                    err_d   = grant_q;
                end else begin
                    busy_cnt_d = busy_inc;
                end
            end
            WAIT_DONE: begin
                if (!bus.i_tx_busy) begin
                    state_d = ACK;
                    ack_d   = grant_q;
                end else if (done_inc == DONE_CNT_W'(DONE_WAIT_MAX)) begin
                    state_d = ERR;
                    err_d   = grant_q;
                end else begin
                    done_cnt_d = done_inc;
                end
            end
            ACK, ERR: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset abandons any message in flight.
    always_ff @(posedge i_divided_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            msg_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            fields_q     <= '0;
            busy_cnt_q   <= '0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            msg_valid_q  <= msg_valid_d;
            data_valid_q <= data_valid_d;
            fields_q     <= fields_d;
            busy_cnt_q   <= busy_cnt_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign bus.o_msg_valid  = msg_valid_q;
    assign bus.o_data_valid = data_valid_q;
    assign bus.o_state      = fields_q.state;
    assign bus.o_sub_state  = fields_q.sub_state;
    assign bus.o_msg_no     = fields_q.msg_no;
    assign bus.o_msg_info   = fields_q.msg_info;
    assign bus.o_data_bus   = fields_q.data;
    assign bus.o_ack        = ack_q;
    assign bus.o_err        = err_q;
    assign bus.o_grant      = grant_q;

endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// Bench for sb_tx_msg_arbiter: transaction-level reference model compared every cycle,
// a simple TX wrapper busy model, requesters that drop on ack/err, and directed scenarios.
module tb_sb_tx_msg_arbiter;

    localparam int N    = 3;
    localparam int BMAX = 15;
    localparam int DMAX = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sb_tx_msg_arbiter_if #(.NUM_REQ(N)) bus ();

    sb_tx_msg_arbiter #(.NUM_REQ(N), .BUSY_WAIT_MAX(BMAX), .DONE_WAIT_MAX(DMAX)) dut (
        .i_divided_clk (clk),
        .i_rst         (rst),
        .bus           (bus)
    );

    int checks = 0;
    int errors = 0;

    // event log
    int ncyc = 0, mv_cyc = -1000, mv_cnt = 0, ack_cyc = 0, err_cyc = 0, ack_cnt = 0;
    logic       mv_dv;
    logic [2:0] end_v, last_ack, last_err;
    logic [2:0] glog[$];
    bit         armed = 0, hold = 0;
    int         busy_len = 10;

    // reference model: owner index, wait progress, round-robin pointer
    int own = -1, ptr = 0, waited = 0;
    bit fin = 0, issued = 0, started = 0;
    logic        e_mv = 0, e_dv = 0;
    logic [2:0]  e_gnt = 0, e_ack = 0, e_err = 0, e_info = 0;
    logic [3:0]  e_st = 0, e_sub = 0, e_no = 0;
    logic [15:0] e_data = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    task automatic model_step();
        int w;
        e_mv = 0; e_dv = 0; e_ack = 0; e_err = 0;
        if (rst) begin
            own = -1; fin = 0; issued = 0; started = 0; waited = 0; ptr = 0;
            e_gnt = 0; e_st = 0; e_sub = 0; e_no = 0; e_info = 0; e_data = 0;
        end else if (fin) begin
            ptr = (own + 1) % N; own = -1; fin = 0; e_gnt = 0;
        end else if (own < 0) begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (ptr + i) % N;
                if (w < 0 && ((bus.i_req >> k) & 3'b1) != 0) w = k;
            end
            if (w >= 0 && !bus.i_fifo_full && !bus.i_tx_busy) begin
                own    = w;
                issued = 1;
                e_gnt  = 3'(1 << w);
                e_mv   = 1;
                e_dv   = ((bus.i_req_has_data >> w) & 3'b1) != 0;
                e_st   = 4'(bus.i_req_state >> (4 * w));
                e_sub  = 4'(bus.i_req_sub_state >> (4 * w));
                e_no   = 4'(bus.i_req_msg_no >> (4 * w));
                e_info = 3'(bus.i_req_msg_info >> (3 * w));
                e_data = e_dv ? 16'(bus.i_req_data >> (16 * w)) : 16'h0;
            end
        end else if (issued) begin
            issued = 0; started = 0; waited = 0;
        end else begin
            waited++;
            if (!started) begin
                if (bus.i_tx_busy) begin started = 1; waited = 0; end
                else if (waited == BMAX) begin fin = 1; e_err = e_gnt; end
            end else begin
                if (!bus.i_tx_busy) begin fin = 1; e_ack = e_gnt; end
                else if (waited == DMAX) begin fin = 1; e_err = e_gnt; end
            end
        end
    endtask

    // One clock: compare at negedge, advance model, then drive wrapper/requesters after posedge.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (armed) begin
            chk("msg_valid",  32'(bus.o_msg_valid),  32'(e_mv));
            chk("data_valid", 32'(bus.o_data_valid), 32'(e_dv));
            chk("grant",      32'(bus.o_grant),      32'(e_gnt));
            chk("ack",        32'(bus.o_ack),        32'(e_ack));
            chk("err",        32'(bus.o_err),        32'(e_err));
            chk("state",      32'(bus.o_state),      32'(e_st));
            chk("sub_state",  32'(bus.o_sub_state),  32'(e_sub));
            chk("msg_no",     32'(bus.o_msg_no),     32'(e_no));
            chk("msg_info",   32'(bus.o_msg_info),   32'(e_info));
            chk("data_bus",   32'(bus.o_data_bus),   32'(e_data));
        end
        if (bus.o_msg_valid === 1'b1) begin
            mv_cyc = ncyc; mv_cnt++; mv_dv = bus.o_data_valid; glog.push_back(bus.o_grant);
        end
        end_v = bus.o_ack | bus.o_err;
        if (|bus.o_ack) begin ack_cyc = ncyc; ack_cnt++; last_ack = bus.o_ack; end
        if (|bus.o_err) begin err_cyc = ncyc; last_err = bus.o_err; end
        model_step();
        if (rst) armed = 1;
        @(posedge clk);
        #1;
        if (!hold) bus.i_req = bus.i_req & ~end_v;
        if (rst) bus.i_tx_busy = 1'b0;
        else if (busy_len > 0 && ncyc == mv_cyc + 1) bus.i_tx_busy = 1'b1;
        else if (bus.i_tx_busy && ncyc == mv_cyc + 1 + busy_len) bus.i_tx_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1;
        bus.i_req = 0; bus.i_fifo_full = 0; hold = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wait_end(input int bound, input string nm);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (|end_v) return;
        end
        chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_mv(input int bound, input string nm);
        int c0;
        c0 = mv_cnt;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (mv_cnt != c0) return;
        end
        chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, a0;
        bus.i_req = 0; bus.i_req_has_data = 0; bus.i_tx_busy = 0; bus.i_fifo_full = 0;
        bus.i_req_state = 12'h321; bus.i_req_sub_state = 12'h654; bus.i_req_msg_no = 12'h987;
        bus.i_req_msg_info = 9'o765; bus.i_req_data = {16'hCCCC, 16'hBBBB, 16'hA55A};

        // 1) single data message; busy 2 cycles after issue, 10 cycles long
        do_reset();
        bus.i_req_has_data = 3'b001; busy_len = 10; bus.i_req = 3'b001;
        wait_end(60, "t1");
        chk("t1_ack", 32'(last_ack), 32'h1);
        chk("t1_ack_latency", 32'(ack_cyc - mv_cyc), 32'd13);
        chk("t1_data_valid", 32'(mv_dv), 32'd1);
        chk("t1_data_bus", 32'(bus.o_data_bus), 32'hA55A);

        // 2) all three held: round-robin 001,010,100,001
        do_reset();
        glog.delete();
        bus.i_req_has_data = 3'b101; busy_len = 3; hold = 1; bus.i_req = 3'b111;
        repeat (4) wait_end(40, "t2");
        hold = 0; bus.i_req = 0;
        repeat (3) tick();
        chk("t2_count", 32'(glog.size()), 32'd4);
        chk("t2_g0", 32'(glog[0]), 32'h1);
        chk("t2_g1", 32'(glog[1]), 32'h2);
        chk("t2_g2", 32'(glog[2]), 32'h4);
        chk("t2_g3", 32'(glog[3]), 32'h1);

        // 3) FIFO full blocks issue; issue right after it clears
        do_reset();
        bus.i_fifo_full = 1; bus.i_req = 3'b010; a0 = mv_cnt;
        repeat (20) tick();
        chk("t3_no_issue_while_full", 32'(mv_cnt - a0), 32'd0);
        bus.i_fifo_full = 0; k = ncyc;
        wait_end(60, "t3");
        chk("t3_issue_cycle", 32'(mv_cyc - k), 32'd2);
        chk("t3_ack", 32'(last_ack), 32'h2);

        // 4) busy never rises: start timeout, then req1 is next
        do_reset();
        busy_len = 0; bus.i_req = 3'b011;
        wait_end(60, "t4");
        chk("t4_err", 32'(last_err), 32'h1);
        chk("t4_err_latency", 32'(err_cyc - mv_cyc), 32'd16);
        busy_len = 4;
        wait_end(60, "t4b");
        chk("t4_next_grant", 32'(glog[$]), 32'h2);
        chk("t4_next_ack", 32'(last_ack), 32'h2);

        // 5) header-only message; inputs changed after grant are ignored
        do_reset();
        bus.i_req_has_data = 3'b000; busy_len = 2;
        bus.i_req_state = 12'h003; bus.i_req_sub_state = 12'h009; bus.i_req_msg_no = 12'h005;
        bus.i_req_msg_info = 9'o006; bus.i_req_data = 48'h0000_0000_BEEF;
        bus.i_req = 3'b001;
        wait_mv(20, "t5");
        bus.i_req_state = 12'hFFF; bus.i_req_msg_no = 12'hEEE; bus.i_req_data = 48'h1234;
        wait_end(60, "t5");
        chk("t5_data_valid", 32'(mv_dv), 32'd0);
        chk("t5_data_bus", 32'(bus.o_data_bus), 32'h0);
        chk("t5_msg_no", 32'(bus.o_msg_no), 32'h5);
        chk("t5_state", 32'(bus.o_state), 32'h3);
        chk("t5_sub_state", 32'(bus.o_sub_state), 32'h9);
        chk("t5_msg_info", 32'(bus.o_msg_info), 32'h6);

        // 6) reset in WAIT_DONE abandons the message without ack
        do_reset();
        bus.i_req_has_data = 3'b001; busy_len = 10; bus.i_req = 3'b001;
        wait_mv(20, "t6");
        repeat (4) tick();
        a0 = ack_cnt;
        rst = 1;
        tick();
        rst = 0;
        chk("t6_grant_cleared", 32'(bus.o_grant), 32'h0);
        chk("t6_fields_cleared", 32'({bus.o_state, bus.o_msg_no, bus.o_data_bus}), 32'h0);
        repeat (3) tick();
        chk("t6_no_ack", 32'(ack_cnt - a0), 32'd0);
        wait_end(60, "t6");
        chk("t6_recover_ack", 32'(last_ack), 32'h1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
